// File: rtl/rom_dl_pkg.sv
// Shared types, lane masks and default address map for the ROM download adapter.
package rom_dl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    LIN  = 2'd0,
    OBJ  = 2'd1,
    PROM = 2'd2,
    DROP = 2'd3
  } region_e;

  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;
  localparam logic [1:0] MASK_NONE = 2'b11;

  localparam logic [24:0] OBJ_START_DEF  = 25'h0026000;
  localparam logic [24:0] OBJ_HALF_DEF   = 25'h0008000;
  localparam logic [24:0] PROM_START_DEF = 25'h0036000;
  localparam logic [24:0] PROM_END_DEF   = 25'h0036A00;

endpackage

// File: rtl/rom_dl_remap.sv
// Combinational byte-address decode into region, ROM word slot, lane mask and PROM offset.
module rom_dl_remap
  import rom_dl_pkg::*;
#(
  parameter logic [24:0] OBJ_START  = OBJ_START_DEF,
  parameter logic [24:0] OBJ_HALF   = OBJ_HALF_DEF,
  parameter logic [24:0] PROM_START = PROM_START_DEF,
  parameter logic [24:0] PROM_END   = PROM_END_DEF
) (
  input  logic [24:0] addr_i,
  output region_e     region_o,
  output logic [16:0] word_addr_o,
  output logic [1:0]  mask_o,
  output logic [11:0] prom_off_o
);

  // The object region is smaller than 2^17 bytes, so a 17-bit offset is exact there.
  logic [16:0] obj_off_s;

  // Region decode and address remap.
  always_comb begin
    obj_off_s   = addr_i[16:0] - OBJ_START[16:0];
    prom_off_o  = addr_i[11:0] - PROM_START[11:0];
    word_addr_o = 17'd0;
    mask_o      = MASK_NONE;
    region_o    = DROP;
    if (addr_i < OBJ_START) begin
      region_o    = LIN;
      word_addr_o = addr_i[17:1];
      mask_o      = addr_i[0] ? MASK_HI : MASK_LO;
    end else if (addr_i < PROM_START) begin
      region_o = OBJ;
      if (obj_off_s < OBJ_HALF[16:0]) begin
        word_addr_o = OBJ_START[17:1] + obj_off_s;
        mask_o      = MASK_LO;
      end else begin
        word_addr_o = OBJ_START[17:1] + (obj_off_s - OBJ_HALF[16:0]);
        mask_o      = MASK_HI;
      end
    end else if (addr_i < PROM_END) begin
      region_o = PROM;
    end else begin
      region_o = DROP;
    end
  end

endmodule

// File: rtl/rom_dl_ctrl.sv
// ioctl download adapter: two-stage byte pipeline to ROM/PROM write ports,
// game reset sequencing and running byte checksum.
module rom_dl_ctrl
  import rom_dl_pkg::*;
#(
  parameter logic [24:0] OBJ_START   = OBJ_START_DEF,
  parameter logic [24:0] OBJ_HALF    = OBJ_HALF_DEF,
  parameter logic [24:0] PROM_START  = PROM_START_DEF,
  parameter logic [24:0] PROM_END    = PROM_END_DEF,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [16:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  output logic [11:0] prom_addr,
  output logic        prom_we,
  output logic        game_rst_n,
  output logic        dl_done,
  output logic [15:0] checksum
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        game_rst_n_q, game_rst_n_d;
  logic        dl_done_q, dl_done_d;
  logic        clear_s, accept_s;

  logic        s1_valid_q, s1_valid_d;
  logic [24:0] s1_addr_q, s1_addr_d;
  logic [7:0]  s1_data_q, s1_data_d;

  logic [16:0] prog_addr_q, prog_addr_d;
  logic [7:0]  prog_data_q, prog_data_d;
  logic [1:0]  prog_mask_q, prog_mask_d;
  logic        prog_we_q, prog_we_d;
  logic [11:0] prom_addr_q, prom_addr_d;
  logic        prom_we_q, prom_we_d;
  logic [15:0] checksum_q, checksum_d;

  region_e     rm_region_s;
  logic [16:0] rm_word_s;
  logic [1:0]  rm_mask_s;
  logic [11:0] rm_prom_s;

  rom_dl_remap #(
    .OBJ_START  (OBJ_START),
    .OBJ_HALF   (OBJ_HALF),
    .PROM_START (PROM_START),
    .PROM_END   (PROM_END)
  ) u_remap (
    .addr_i      (s1_addr_q),
    .region_o    (rm_region_s),
    .word_addr_o (rm_word_s),
    .mask_o      (rm_mask_s),
    .prom_off_o  (rm_prom_s)
  );

  // Download sequencer; cnt_q times both the two-cycle drain and the reset hold.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dl_done_d = 1'b0;
    clear_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ioctl_download) begin
          state_d = LOAD;
          clear_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (!ioctl_download) begin
          state_d = DRAIN;
          cnt_d   = 8'd1;
        end else begin
          state_d = LOAD;
        end
      end
      DRAIN: begin
        if (cnt_q == 8'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (ioctl_download) begin
          state_d = LOAD;
          clear_s = 1'b1;
        end else if (cnt_q == 8'd0) begin
          state_d   = IDLE;
          dl_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    game_rst_n_d = (state_d == IDLE);
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      game_rst_n_q <= 1'b0;
      dl_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      game_rst_n_q <= game_rst_n_d;
      dl_done_q    <= dl_done_d;
    end
  end

  // Byte pipeline: stage 1 captures accepted bytes, stage 2 builds the write strobes.
  always_comb begin
    accept_s    = ioctl_wr & ioctl_download & (state_q == LOAD);
    s1_valid_d  = accept_s;
    s1_addr_d   = accept_s ? ioctl_addr : s1_addr_q;
    s1_data_d   = accept_s ? ioctl_dout : s1_data_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    prog_mask_d = MASK_NONE;
    prog_we_d   = 1'b0;
    prom_addr_d = prom_addr_q;
    prom_we_d   = 1'b0;
    if (clear_s) begin
      checksum_d = 16'd0;
    end else if (s1_valid_q) begin
      checksum_d = checksum_q + {8'd0, s1_data_q};
    end else begin
      checksum_d = checksum_q;
    end
    if (s1_valid_q) begin
      case (rm_region_s)
        LIN, OBJ: begin
          prog_we_d   = 1'b1;
          prog_addr_d = rm_word_s;
          prog_mask_d = rm_mask_s;
          prog_data_d = s1_data_q;
        end
        PROM: begin
          prom_we_d   = 1'b1;
          prom_addr_d = rm_prom_s;
          prog_data_d = s1_data_q;
        end
        default: begin
          prog_we_d = 1'b0;
        end
      endcase
    end else begin
      prog_we_d = 1'b0;
    end
  end

  // Pipeline and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= 25'd0;
      s1_data_q   <= 8'd0;
      prog_addr_q <= 17'd0;
      prog_data_q <= 8'd0;
      prog_mask_q <= MASK_NONE;
      prog_we_q   <= 1'b0;
      prom_addr_q <= 12'd0;
      prom_we_q   <= 1'b0;
      checksum_q  <= 16'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      s1_data_q   <= s1_data_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      prog_mask_q <= prog_mask_d;
      prog_we_q   <= prog_we_d;
      prom_addr_q <= prom_addr_d;
      prom_we_q   <= prom_we_d;
      checksum_q  <= checksum_d;
    end
  end

  assign prog_addr  = prog_addr_q;
  assign prog_data  = prog_data_q;
  assign prog_mask  = prog_mask_q;
  assign prog_we    = prog_we_q;
  assign prom_addr  = prom_addr_q;
  assign prom_we    = prom_we_q;
  assign game_rst_n = game_rst_n_q;
  assign dl_done    = dl_done_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Randomized bench for rom_dl_ctrl against a cycle-level behavioural model of the download rules.
module tb_rom_dl_ctrl;

  localparam int OBJ_S  = 'h26000;
  localparam int OBJ_H  = 'h8000;
  localparam int PROM_S = 'h36000;
  localparam int PROM_E = 'h36A00;
  localparam int RUNDOWN_LAST = 17;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [16:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic [11:0] prom_addr;
  logic        prom_we;
  logic        game_rst_n;
  logic        dl_done;
  logic [15:0] checksum;

  always #5 clk = ~clk;

  rom_dl_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .prog_mask      (prog_mask),
    .prog_we        (prog_we),
    .prom_addr      (prom_addr),
    .prom_we        (prom_we),
    .game_rst_n     (game_rst_n),
    .dl_done        (dl_done),
    .checksum       (checksum)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 loading, 2 running down (drain + hold as one 18-cycle window)
  int m_mode, m_run;
  bit pend_v;
  int pend_a, pend_d;
  int e_paddr, e_pdata, e_mask, e_pwe, e_praddr, e_prwe, e_grst, e_done, e_csum;

  task automatic model_reset();
    m_mode = 0; m_run = 0; pend_v = 1'b0; pend_a = 0; pend_d = 0;
    e_paddr = 0; e_pdata = 0; e_mask = 3; e_pwe = 0; e_praddr = 0; e_prwe = 0;
    e_grst = 0; e_done = 0; e_csum = 0;
  endtask

  task automatic model_edge();
    int a, o;
    e_pwe = 0; e_prwe = 0; e_mask = 3; e_done = 0;
    if (pend_v) begin
      a = pend_a;
      if (a < OBJ_S) begin
        e_pwe = 1; e_paddr = a / 2; e_mask = (a % 2 == 1) ? 1 : 2; e_pdata = pend_d;
      end else if (a < PROM_S) begin
        o = a - OBJ_S;
        e_pwe = 1; e_paddr = OBJ_S / 2 + (o % OBJ_H); e_mask = (o >= OBJ_H) ? 1 : 2; e_pdata = pend_d;
      end else if (a < PROM_E) begin
        e_prwe = 1; e_praddr = a - PROM_S; e_pdata = pend_d;
      end
      e_csum = (e_csum + pend_d) % 65536;
    end
    pend_v = (m_mode == 1) && ioctl_wr && ioctl_download;
    pend_a = int'(ioctl_addr);
    pend_d = int'(ioctl_dout);
    if (m_mode == 0) begin
      if (ioctl_download) begin m_mode = 1; e_csum = 0; end
    end else if (m_mode == 1) begin
      if (!ioctl_download) begin m_mode = 2; m_run = 0; end
    end else begin
      if (m_run >= 2 && ioctl_download) begin
        m_mode = 1; e_csum = 0;
      end else if (m_run == RUNDOWN_LAST) begin
        m_mode = 0; e_done = 1;
      end else begin
        m_run++;
      end
    end
    e_grst = (m_mode == 0) ? 1 : 0;
  endtask

  task automatic compare_all();
    check_eq("prog_we", prog_we, e_pwe);
    check_eq("prog_mask", prog_mask, e_mask);
    check_eq("prog_addr", prog_addr, e_paddr);
    check_eq("prog_data", prog_data, e_pdata);
    check_eq("prom_we", prom_we, e_prwe);
    check_eq("prom_addr", prom_addr, e_praddr);
    check_eq("game_rst_n", game_rst_n, e_grst);
    check_eq("dl_done", dl_done, e_done);
    check_eq("checksum", checksum, e_csum);
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  function automatic logic [24:0] rand_addr();
    case ($urandom_range(0, 12))
      0:       return 25'($urandom_range(0, OBJ_S - 1));
      1:       return 25'(OBJ_S + $urandom_range(0, OBJ_H - 1));
      2:       return 25'(OBJ_S + OBJ_H + $urandom_range(0, OBJ_H - 1));
      3:       return 25'(PROM_S + $urandom_range(0, PROM_E - PROM_S - 1));
      4:       return 25'(PROM_E + $urandom_range(0, 'h1000));
      5:       return 25'(OBJ_S - 1);
      6:       return 25'(OBJ_S);
      7:       return 25'(OBJ_S + OBJ_H - 1);
      8:       return 25'(OBJ_S + OBJ_H);
      9:       return 25'(PROM_S - 1);
      10:      return 25'(PROM_S);
      11:      return 25'(PROM_E - 1);
      default: return 25'h1FFFFFF;
    endcase
  endfunction

  task automatic put_byte(input int a, input int d);
    ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = 8'(d);
    step();
    ioctl_wr = 1'b0;
  endtask

  task automatic mid_reset();
    ioctl_download = 1'b1;
    repeat (3) begin
      ioctl_wr = 1'b1; ioctl_addr = rand_addr(); ioctl_dout = 8'($urandom);
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    ioctl_download = 1'b0;
    ioctl_wr = 1'b1;
    rst_n = 1'b1;
    step();
    step();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // idle with stray strobes and no download
    repeat (5) begin
      ioctl_wr = 1'($urandom); ioctl_addr = rand_addr(); ioctl_dout = 8'($urandom);
      step();
    end

    // directed bytes across all regions
    ioctl_wr = 1'b0; ioctl_download = 1'b1;
    step();
    put_byte('h00000, 'hAA);
    put_byte('h00001, 'h55);
    put_byte('h26004, 'h11);
    put_byte('h2E004, 'h22);
    put_byte('h36105, 'h7F);
    put_byte('h36A00, 'h33);
    repeat (2) step();
    check_eq("checksum_directed", checksum, 32'h000001E4);
    ioctl_download = 1'b0;
    repeat (20) step();

    // re-raise download during the hold phase
    ioctl_download = 1'b1;
    step();
    put_byte('h00010, 'h5A);
    ioctl_download = 1'b0;
    repeat (7) step();
    ioctl_download = 1'b1;
    repeat (3) step();
    ioctl_download = 1'b0;
    repeat (20) step();

    // random downloads with random rundown lengths
    for (int it = 0; it < 10; it++) begin
      if (it == 4) mid_reset();
      ioctl_download = 1'b1;
      repeat ($urandom_range(5, 40)) begin
        ioctl_wr = ($urandom_range(0, 3) != 0); ioctl_addr = rand_addr(); ioctl_dout = 8'($urandom);
        step();
      end
      ioctl_download = 1'b0;
      repeat ($urandom_range(1, 24)) begin
        ioctl_wr = 1'($urandom); ioctl_addr = rand_addr(); ioctl_dout = 8'($urandom);
        step();
      end
    end
    ioctl_download = 1'b0; ioctl_wr = 1'b0;
    repeat (25) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
